// File: rtl/square_pipelined.sv
// square_pipelined: one shift-add stage per root bit, ce-gated pipeline; SQUARE_PIPELINED_REMAINDER_EN adds remainder/rem_err
module square_pipelined #(
  parameter int INPUT_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      start,
  input  logic [INPUT_BITS-1:0]     root,
`ifdef SQUARE_PIPELINED_REMAINDER_EN
  input  logic [INPUT_BITS:0]       remainder,
  output logic                      rem_err,
`endif
  output logic                      data_valid,
  output logic [2*INPUT_BITS-1:0]   square
);
  localparam int OUTPUT_BITS = 2 * INPUT_BITS;
  logic [OUTPUT_BITS-1:0] r_acc [INPUT_BITS];
  logic [INPUT_BITS-1:0]  r_op  [INPUT_BITS];
  logic [INPUT_BITS-1:0]  r_v;
  logic [OUTPUT_BITS-1:0] w_result;
`ifdef SQUARE_PIPELINED_REMAINDER_EN
  logic [INPUT_BITS:0]    r_rem [INPUT_BITS];
  assign w_result = r_acc[INPUT_BITS-1] + OUTPUT_BITS'(r_rem[INPUT_BITS-1]);
`else
  assign w_result = r_acc[INPUT_BITS-1];
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < INPUT_BITS; k++) begin
        r_acc[k] <= '0;
        r_op[k]  <= '0;
`ifdef SQUARE_PIPELINED_REMAINDER_EN
        r_rem[k] <= '0;
`endif
      end
      r_v        <= '0;
      square     <= '0;
      data_valid <= 1'b0;
`ifdef SQUARE_PIPELINED_REMAINDER_EN
      rem_err    <= 1'b0;
`endif
    end else if (ce) begin
      r_op[0]  <= root;
      r_acc[0] <= root[0] ? OUTPUT_BITS'(root) : '0;
      r_v[0]   <= start;
`ifdef SQUARE_PIPELINED_REMAINDER_EN
      r_rem[0] <= remainder;
`endif
      // stage k adds the partial product for operand bit k
      for (int k = 1; k < INPUT_BITS; k++) begin
        r_acc[k] <= r_acc[k-1] + (r_op[k-1][k] ? (OUTPUT_BITS'(r_op[k-1]) << k) : '0);
        r_op[k]  <= r_op[k-1];
        r_v[k]   <= r_v[k-1];
`ifdef SQUARE_PIPELINED_REMAINDER_EN
        r_rem[k] <= r_rem[k-1];
`endif
      end
      square     <= w_result;
      data_valid <= r_v[INPUT_BITS-1];
`ifdef SQUARE_PIPELINED_REMAINDER_EN
      rem_err    <= r_rem[INPUT_BITS-1] > {r_op[INPUT_BITS-1], 1'b0};
`endif
    end
  end
endmodule
